// File: rtl/regfile_tagged_if.sv
// Issue/rename/commit bus for the tagged register file.
// master = decode/issue/commit side, slave = the register file.
interface regfile_tagged_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int TAGW  = 4
);
  localparam int AW = $clog2(NREGS);

  logic [NRD-1:0]      rd_en_i;
  logic [NRD*AW-1:0]   rd_addr_i;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic [NRD-1:0]      rd_busy_o;
  logic [NRD*TAGW-1:0] rd_tag_o;

  logic                rn_en_i;
  logic [AW-1:0]       rn_addr_i;
  logic [TAGW-1:0]     rn_tag_i;

  logic                wb_en_i;
  logic [AW-1:0]       wb_addr_i;
  logic [TAGW-1:0]     wb_tag_i;
  logic [XLEN-1:0]     wb_data_i;

  logic                flush_i;

  modport master (
    output rd_en_i, rd_addr_i, rn_en_i, rn_addr_i, rn_tag_i,
           wb_en_i, wb_addr_i, wb_tag_i, wb_data_i, flush_i,
    input  rd_data_o, rd_busy_o, rd_tag_o
  );

  modport slave (
    input  rd_en_i, rd_addr_i, rn_en_i, rn_addr_i, rn_tag_i,
           wb_en_i, wb_addr_i, wb_tag_i, wb_data_i, flush_i,
    output rd_data_o, rd_busy_o, rd_tag_o
  );
endinterface

// File: rtl/regfile_tagged.sv
// Register file with per-register busy/tag scoreboard, commit bypass and flush.
// Define REGFILE_TRACE_EN to build the registered commit trace (dbg_*) outputs.
module regfile_tagged #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int TAGW  = 4,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  regfile_tagged_if.slave bus,
  output logic [AW:0]     busy_cnt_o,
  output logic            dbg_wr_valid_o,
  output logic [AW-1:0]   dbg_wr_addr_o,
  output logic [XLEN-1:0] dbg_wr_data_o
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [TAGW-1:0]  tag_q  [NREGS];
  logic [TAGW-1:0]  tag_d  [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      busy_cnt_q, busy_cnt_d;

  logic [NRD-1:0]   wb_hit;
  logic             wb_valid, rn_valid, commit_clear, cnt_inc, cnt_dec;

  // A read sees the committing value if it retires the current producer or the register is idle
  for (genvar k = 0; k < NRD; k++) begin : g_hit
    logic [AW-1:0] addr;
    assign addr      = bus.rd_addr_i[k*AW +: AW];
    assign wb_hit[k] = bus.wb_en_i && (bus.wb_addr_i == addr) &&
                       (!busy_q[addr] || (tag_q[addr] == bus.wb_tag_i));
  end

  always_comb begin
    bus.rd_data_o = '0;
    bus.rd_busy_o = '0;
    bus.rd_tag_o  = '0;
    for (int k = 0; k < NRD; k++) begin
      if (!rst && bus.rd_en_i[k] && (bus.rd_addr_i[k*AW +: AW] != '0)) begin
        if (wb_hit[k]) begin
          bus.rd_data_o[k*XLEN +: XLEN] = bus.wb_data_i;
        end else begin
          bus.rd_data_o[k*XLEN +: XLEN] = regs_q[bus.rd_addr_i[k*AW +: AW]];
          bus.rd_busy_o[k]              = busy_q[bus.rd_addr_i[k*AW +: AW]];
          bus.rd_tag_o[k*TAGW +: TAGW]  = tag_q[bus.rd_addr_i[k*AW +: AW]];
        end
      end
    end
  end

  assign wb_valid     = bus.wb_en_i && (bus.wb_addr_i != '0);
  assign rn_valid     = bus.rn_en_i && (bus.rn_addr_i != '0) && !bus.flush_i;
  assign commit_clear = wb_valid && busy_q[bus.wb_addr_i] &&
                        (tag_q[bus.wb_addr_i] == bus.wb_tag_i) &&
                        !(bus.rn_en_i && (bus.rn_addr_i == bus.wb_addr_i));
  assign cnt_inc      = rn_valid && !busy_q[bus.rn_addr_i];
  assign cnt_dec      = commit_clear;

  // Commit writes data first; rename then overrides busy/tag; flush overrides everything busy-related
  always_comb begin
    regs_d     = regs_q;
    tag_d      = tag_q;
    busy_d     = busy_q;
    busy_cnt_d = busy_cnt_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
    if (wb_valid) begin
      regs_d[bus.wb_addr_i] = bus.wb_data_i;
      if (commit_clear) begin
        busy_d[bus.wb_addr_i] = 1'b0;
      end
    end
    if (rn_valid) begin
      busy_d[bus.rn_addr_i] = 1'b1;
      tag_d[bus.rn_addr_i]  = bus.rn_tag_i;
    end
    if (bus.flush_i) begin
      busy_d     = '0;
      busy_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      tag_q      <= tag_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt_o = busy_cnt_q;

`ifdef REGFILE_TRACE_EN
  logic            dbg_valid_q, dbg_valid_d;
  logic [AW-1:0]   dbg_addr_q, dbg_addr_d;
  logic [XLEN-1:0] dbg_data_q, dbg_data_d;

  always_comb begin
    dbg_valid_d = wb_valid;
    dbg_addr_d  = dbg_addr_q;
    dbg_data_d  = dbg_data_q;
    if (wb_valid) begin
      dbg_addr_d = bus.wb_addr_i;
      dbg_data_d = bus.wb_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_valid_q <= 1'b0;
      dbg_addr_q  <= '0;
      dbg_data_q  <= '0;
    end else begin
      dbg_valid_q <= dbg_valid_d;
      dbg_addr_q  <= dbg_addr_d;
      dbg_data_q  <= dbg_data_d;
    end
  end

  assign dbg_wr_valid_o = dbg_valid_q;
  assign dbg_wr_addr_o  = dbg_addr_q;
  assign dbg_wr_data_o  = dbg_data_q;
`else
  assign dbg_wr_valid_o = 1'b0;
  assign dbg_wr_addr_o  = '0;
  assign dbg_wr_data_o  = '0;
`endif

endmodule
